// File: rtl/mau_pkg.sv
// mau_pkg: op/state encodings and stack bounds for mem_access_unit.
// Shared by the unit, its stack pointer and the request interface.
package mau_pkg;

  typedef enum logic [2:0] {
    OP_LB   = 3'b000,
    OP_SB   = 3'b001,
    OP_LH   = 3'b010,
    OP_SH   = 3'b011,
    OP_PUSH = 3'b100,
    OP_POP  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_DONE
  } state_e;

  localparam logic [7:0] SP_RESET_DEF    = 8'hFF;
  localparam logic [7:0] STACK_LIMIT_DEF = 8'hC0;

  function automatic logic op_legal(input logic [2:0] op);
    return op[2:1] != 2'b11;
  endfunction

endpackage

// File: rtl/mau_if.sv
// mau_if: core request/response handshake for mem_access_unit.
// Ports: req_valid/ready/op/addr/wdata in, rsp_valid/data/fault out.
interface mau_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_fault;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_fault
  );

endinterface

// File: rtl/mau_stack_ptr.sv
// mau_stack_ptr: stack pointer register with full/empty compare.
// Ports: clk, reset, inc, dec in; sp, sp_m1, full, empty out.
module mau_stack_ptr
  import mau_pkg::*;
#(
  parameter logic [7:0] SP_RESET    = SP_RESET_DEF,
  parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] sp,
  output logic [7:0] sp_m1,
  output logic       full,
  output logic       empty
);

  logic [7:0] sp_q;
  logic [7:0] sp_d;

  always_comb begin
    sp_d = sp_q;
    unique case (1'b1)
      inc:     sp_d = sp_q + 8'd1;
      dec:     sp_d = sp_q - 8'd1;
      default: sp_d = sp_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= SP_RESET;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign sp    = sp_q;
  assign sp_m1 = sp_q - 8'd1;
  assign full  = (sp_q == STACK_LIMIT);
  assign empty = (sp_q == SP_RESET);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store/stack sequencer in front of an 8x256 RAM.
// Ports: clk, reset, core (mau_if.slave), sp_out, mem_addr/dat_in/wr_en/dat_out.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [7:0] SP_RESET    = SP_RESET_DEF,
  parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mau_if.slave       core,
  output logic [7:0] sp_out,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_dat_in,
  output logic       mem_wr_en,
  input  logic [7:0] mem_dat_out
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic       sp_inc, sp_dec;
  logic [7:0] sp, sp_m1;
  logic       sp_full, sp_empty;
  logic       wr;
  logic       chk_fault;

  logic is_push, is_pop, is_store, is_half;

  assign is_push  = (op_q == OP_PUSH);
  assign is_pop   = (op_q == OP_POP);
  assign is_store = (op_q == OP_SB) || (op_q == OP_SH);
  assign is_half  = (op_q == OP_LH) || (op_q == OP_SH);

  mau_stack_ptr #(
    .SP_RESET    (SP_RESET),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .clk   (clk),
    .reset (reset),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .sp    (sp),
    .sp_m1 (sp_m1),
    .full  (sp_full),
    .empty (sp_empty)
  );

  // Faulting requests skip memory entirely and go straight to DONE.
  always_comb begin
    chk_fault = !op_legal(core.req_op);
    if (core.req_op == OP_PUSH && sp_full)  chk_fault = 1'b1;
    if (core.req_op == OP_POP  && sp_empty) chk_fault = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;

    sp_inc     = 1'b0;
    sp_dec     = 1'b0;
    mem_addr   = 8'h00;
    mem_dat_in = 8'h00;
    wr         = 1'b0;

    core.req_ready = 1'b0;
    core.rsp_valid = 1'b0;
    core.rsp_data  = 16'h0000;
    core.rsp_fault = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        core.req_ready = 1'b1;
        if (core.req_valid) begin
          op_d    = core.req_op;
          addr_d  = core.req_addr;
          wdata_d = core.req_wdata;
          rdata_d = 16'h0000;
          fault_d = chk_fault;
          state_d = chk_fault ? S_DONE : S_ACC0;
        end
      end
      S_ACC0: begin
        mem_addr = addr_q;
        state_d  = is_half ? S_ACC1 : S_DONE;
        unique case (1'b1)
          is_push: begin
            mem_addr   = sp_m1;
            mem_dat_in = wdata_q[7:0];
            wr         = 1'b1;
            sp_dec     = 1'b1;
          end
          is_pop: begin
            mem_addr     = sp;
            rdata_d[7:0] = mem_dat_out;
            sp_inc       = 1'b1;
          end
          is_store: begin
            mem_dat_in = wdata_q[7:0];
            wr         = 1'b1;
          end
          default: rdata_d[7:0] = mem_dat_out;
        endcase
      end
      S_ACC1: begin
        mem_addr = addr_q + 8'd1;
        state_d  = S_DONE;
        if (is_store) begin
          mem_dat_in = wdata_q[15:8];
          wr         = 1'b1;
        end else begin
          rdata_d[15:8] = mem_dat_out;
        end
      end
      S_DONE: begin
        core.rsp_valid = 1'b1;
        core.rsp_data  = rdata_q;
        core.rsp_fault = fault_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset aborts the access on the same edge, so suppress its write too.
  assign mem_wr_en = wr & ~reset;
  assign sp_out    = sp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      addr_q  <= 8'h00;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

endmodule
